tlv493_sample_filter: RTL
=========================

# tlv493_sample_filter

Downstream stage of the TLV493 sensor controller. Consumes each completed magnetic frame (`mag_x/y/z` and the `frm` counter) and subtracts per-axis calibration offsets. It maintains an N-sample boxcar moving average per axis and publishes averaged values with a valid strobe. It also checks frame-counter continuity, flushing the average on any gap, and counts gaps and overruns for software.

## Interface
- `AVG_LOG2`, default 3: log2 of window length N; legal range 0..4 (N = 1..16).
- `clock` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `sample_valid` in 1: one-cycle strobe; `mag_*`, `frm` and `offset_*` are valid in that cycle.
- `mag_x`, `mag_y`, `mag_z` in 12 each: raw field sample, two's complement.
- `frm` in 2: sensor frame counter of this sample.
- `offset_x`, `offset_y`, `offset_z` in 12 each: calibration offset, two's complement, captured with the sample.
- `clear` in 1: synchronous flush of window, counters and frame history.
- `busy` out 1: processing a captured sample; new strobes are dropped while high.
- `out_valid` out 1: one-cycle strobe; `avg_*` updated in the same cycle.
- `avg_x`, `avg_y`, `avg_z` out 16 each: averaged field, two's complement, held between strobes.
- `frame_errors` out 16: count of frame-counter discontinuities, saturating at 16'hFFFF.
- `overruns` out 8: count of strobes dropped while busy, saturating at 8'hFF.

## Operation
- Reset values: `busy` 0, `out_valid` 0, `avg_*` 0, `frame_errors` 0, `overruns` 0, fill count 0, running sums 0, write pointer 0, frame history invalid.
- FSM states: IDLE, AX_X, AX_Y, AX_Z, EMIT.
  - IDLE: on `sample_valid`, register inputs and go to AX_X.
  - AX_X, AX_Y, AX_Z: each processes one axis per cycle, then advances to the next state.
  - EMIT: returns to IDLE.
- Offset stage: `d = sext13(mag) - sext13(offset)`. The result is an exact 13-bit signed value with no saturation.
- Ring buffer: one per axis, N entries of 13 bits, shared write pointer of AVG_LOG2 bits that wraps modulo N. Running sum per axis is (13+AVG_LOG2) bits signed.
- Per axis step: `sum <= sum + d - (fill==N ? buf[wp] : 0)`, then `buf[wp] <= d`.
- EMIT phase:
  - Advance `wp` (mod N).
  - Increment fill if fill<N.
  - If fill (after increment) == N: assert `out_valid` and set `avg = sext16(sum >>> AVG_LOG2)`. The shift is arithmetic, so the result rounds toward minus infinity.
  - If fill < N, `avg_*` hold and `out_valid` stays 0.
- Frame check at capture: if history is valid and `frm != last_frm+1 (mod 4)`:
  - Increment `frame_errors` (saturating).
  - Flush the window: fill 0, sums 0, `wp` 0.
  - Process the current sample as the first sample of the new window.
  - In all cases, store `last_frm = frm` and mark history valid.
- First sample after reset or `clear`: no continuity check is made.
- `sample_valid` while `busy`: sample ignored, `overruns` incremented (saturating), no other state change.
- `clear` has highest priority, in any state:
  - Return to IDLE and deassert `busy`/`out_valid`.
  - Zero fill, sums, `wp`, `frame_errors` and `overruns`; invalidate history.
  - Hold `avg_*`.
  - A simultaneous `sample_valid` is discarded and not counted.
- Async reset mid-processing: immediate return to the reset values listed above; the in-flight sample is lost.

## Timing
- `sample_valid` in cycle 0 → AX_X in cycle 1, AX_Y in 2, AX_Z in 3, EMIT in 4.
- `out_valid` is high in cycle 4 (latency 4).
- `busy` is high in cycles 1..4. The earliest next accepted strobe is cycle 5 (throughput 1 sample / 5 cycles).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Counters update in the cycle after the triggering event (cycle 1 for a frame error, the strobe cycle + 1 for an overrun).

## Test plan
- Window fill, AVG_LOG2=3, offsets 0: 8 strobes with `mag_x`=100, `mag_y`=-50, `mag_z`=0, frm 0,1,2,3,0,1,2,3.
  - No `out_valid` for strobes 1–7.
  - On strobe 8, `out_valid` fires 4 cycles after the strobe with `avg_x`=100, `avg_y`=16'hFFCE, `avg_z`=0.
  - Strobe 9 with `mag_x`=180: `avg_x`=110.
- Floor rounding: window of seven `mag_x`=0 plus one `mag_x`=-1 → `avg_x` = 16'hFFFF (−1).
- Offset extremes, AVG_LOG2=0: `mag_x`=-2048, `offset_x`=2047 → `avg_x` = 16'hF001 (−4095), `out_valid` on the first strobe.
- Frame gap: frm 0,1,3 → `frame_errors`=1, and the next `out_valid` occurs only on the 8th sample counted from the frm=3 sample. Sequence 3→0 wraps without error.
- Overrun and saturation:
  - Strobes in cycles 0 and 2 → second dropped, `overruns`=1, exactly one `out_valid` (cycle 4).
  - 300 dropped strobes → `overruns`=8'hFF.
- Clear/reset:
  - `clear` together with a strobe in cycle 2 of processing → no `out_valid`, counters 0, fill restarts.
  - `reset_n` low in AX_Y → all outputs at their reset values while low; the next full window averages correctly.

Source files
------------

// File: rtl/tlv493_sample_filter.sv
// Per-axis offset removal and N-sample boxcar average for TLV493 frames, with
// frame-counter continuity checking and software-visible gap/overrun counters.
module tlv493_sample_filter #(
  parameter int AVG_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [11:0] mag_x,
  input  logic [11:0] mag_y,
  input  logic [11:0] mag_z,
  input  logic [1:0]  frm,
  input  logic [11:0] offset_x,
  input  logic [11:0] offset_y,
  input  logic [11:0] offset_z,
  input  logic        clear,
  output logic        busy,
  output logic        out_valid,
  output logic [15:0] avg_x,
  output logic [15:0] avg_y,
  output logic [15:0] avg_z,
  output logic [15:0] frame_errors,
  output logic [7:0]  overruns,
  output logic [2:0]  dbg_state
);
  // Handshake: sample_valid is a one-cycle strobe, accepted only when busy is low;
  // out_valid is a one-cycle strobe with avg_* updated in that same cycle.
  typedef enum logic [2:0] {IDLE, AX_X, AX_Y, AX_Z, EMIT} state_t;

  localparam int N     = 1 << AVG_LOG2;
  localparam int SW    = 13 + AVG_LOG2;
  localparam int PW    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int FW    = AVG_LOG2 + 1;
  localparam int DEPTH = 1 << PW;
  localparam logic [FW-1:0] FULL    = FW'(N);
  localparam logic [PW-1:0] WP_LAST = PW'(N - 1);

  state_t state, state_nx;

  logic signed [12:0]   d_x, d_y, d_z;
  logic signed [SW-1:0] sum_x, sum_y, sum_z;
  logic signed [SW-1:0] sum_x_nx, sum_y_nx, sum_z_nx;
  logic signed [12:0]   ring_x [DEPTH];
  logic signed [12:0]   ring_y [DEPTH];
  logic signed [12:0]   ring_z [DEPTH];
  logic [FW-1:0]        fill, fill_inc;
  logic [PW-1:0]        wp, wp_nx;
  logic                 hist_valid;
  logic [1:0]           last_frm;
  logic                 full, gap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_valid) state_nx = AX_X;
      AX_X:    state_nx = AX_Y;
      AX_Y:    state_nx = AX_Z;
      AX_Z:    state_nx = EMIT;
      EMIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Once the window is full, the oldest entry at wp leaves as the new one enters.
  always_comb begin
    full     = (fill == FULL);
    gap      = hist_valid && (frm != last_frm + 2'd1);
    sum_x_nx = sum_x + SW'(d_x) - (full ? SW'(ring_x[wp]) : SW'(0));
    sum_y_nx = sum_y + SW'(d_y) - (full ? SW'(ring_y[wp]) : SW'(0));
    sum_z_nx = sum_z + SW'(d_z) - (full ? SW'(ring_z[wp]) : SW'(0));
    fill_inc = full ? fill : fill + FW'(1);
    wp_nx    = (wp == WP_LAST) ? '0 : wp + PW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      avg_x        <= '0;
      avg_y        <= '0;
      avg_z        <= '0;
      frame_errors <= '0;
      overruns     <= '0;
      fill         <= '0;
      wp           <= '0;
      sum_x        <= '0;
      sum_y        <= '0;
      sum_z        <= '0;
      d_x          <= '0;
      d_y          <= '0;
      d_z          <= '0;
      hist_valid   <= 1'b0;
      last_frm     <= '0;
    end else if (clear) begin
      out_valid    <= 1'b0;
      frame_errors <= '0;
      overruns     <= '0;
      fill         <= '0;
      wp           <= '0;
      sum_x        <= '0;
      sum_y        <= '0;
      sum_z        <= '0;
      hist_valid   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample_valid && state != IDLE && overruns != 8'hFF)
        overruns <= overruns + 8'd1;
      case (state)
        IDLE: if (sample_valid) begin
          d_x        <= 13'(signed'(mag_x)) - 13'(signed'(offset_x));
          d_y        <= 13'(signed'(mag_y)) - 13'(signed'(offset_y));
          d_z        <= 13'(signed'(mag_z)) - 13'(signed'(offset_z));
          last_frm   <= frm;
          hist_valid <= 1'b1;
          if (gap) begin
            if (frame_errors != 16'hFFFF) frame_errors <= frame_errors + 16'd1;
            fill  <= '0;
            wp    <= '0;
            sum_x <= '0;
            sum_y <= '0;
            sum_z <= '0;
          end
        end
        AX_X: sum_x <= sum_x_nx;
        AX_Y: sum_y <= sum_y_nx;
        // Window bookkeeping is folded into the AX_Z edge so out_valid and
        // avg_* are registered outputs during the EMIT cycle.
        AX_Z: begin
          sum_z <= sum_z_nx;
          wp    <= wp_nx;
          fill  <= fill_inc;
          if (fill_inc == FULL) begin
            out_valid <= 1'b1;
            avg_x     <= 16'(sum_x >>> AVG_LOG2);
            avg_y     <= 16'(sum_y >>> AVG_LOG2);
            avg_z     <= 16'(sum_z_nx >>> AVG_LOG2);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      case (state)
        AX_X:    ring_x[wp] <= d_x;
        AX_Y:    ring_y[wp] <= d_y;
        AX_Z:    ring_z[wp] <= d_z;
        default: ;
      endcase
    end
  end
endmodule
